// File: rtl/serdes_lb_checker.sv
// SERDES loopback receive checker: hunts for the comma-marked loopback word,
// locks onto its byte position and counts checked words and word errors.
module serdes_lb_checker #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter logic [7:0]  FILL       = 8'h4A,
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic        rx_clk,
  input  logic        rstn_i,
  input  logic        rx_valid_i,
  input  logic [63:0] rx_data_i,
  input  logic [7:0]  rx_char_is_k_i,
  input  logic [7:0]  rx_not_in_table_i,
  input  logic [7:0]  rx_disp_err_i,
  input  logic        cnt_clr_i,
  output logic        locked_o,
  output logic [2:0]  k_pos_o,
  output logic        err_o,
  output logic [31:0] err_cnt_o,
  output logic [47:0] word_cnt_o
);

  localparam logic [7:0] LP_LOCK   = 8'(LOCK_CNT);
  localparam logic [7:0] LP_UNLOCK = 8'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Stage 1: input capture
  logic        r_valid;
  logic [63:0] r_data;
  logic [7:0]  r_k;
  logic [7:0]  r_nit;
  logic [7:0]  r_disp;
  logic        r_clr;

  // Stage 2: tracking state and counters
  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_run;
  logic [7:0]  w_run_nxt;
  logic [2:0]  r_kpos;
  logic [2:0]  w_kpos_nxt;
  logic        r_err;
  logic [31:0] r_err_cnt;
  logic [47:0] r_word_cnt;

  logic        w_code_err;
  logic [7:0]  w_is_comma;
  logic [7:0]  w_is_fill;
  logic [7:0]  w_cand;
  logic [2:0]  w_cand_pos;
  logic        w_any_cand;
  logic        w_good;
  logic        w_word_inc;
  logic        w_bad_locked;

  always_ff @(posedge rx_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_k     <= '0;
      r_nit   <= '0;
      r_disp  <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_valid <= rx_valid_i;
      r_data  <= rx_data_i;
      r_k     <= rx_char_is_k_i;
      r_nit   <= rx_not_in_table_i;
      r_disp  <= rx_disp_err_i;
      r_clr   <= cnt_clr_i;
    end
  end

  // A candidate at p needs a clean word, K only on byte p, comma there and fill elsewhere.
  always_comb begin
    w_code_err = (|r_nit) | (|r_disp);
    w_is_comma = '0;
    w_is_fill  = '0;
    w_cand     = '0;
    w_cand_pos = '0;
    for (int b = 0; b < 8; b++) begin
      w_is_comma[b] = (r_data[8*b +: 8] == COMMA);
      w_is_fill[b]  = (r_data[8*b +: 8] == FILL);
    end
    for (int p = 0; p < 8; p++) begin
      w_cand[p] = !w_code_err && (r_k == (8'b1 << p)) && w_is_comma[p] &&
                  ((w_is_fill | (8'b1 << p)) == 8'hFF);
    end
    for (int p = 7; p >= 0; p--) begin
      if (w_cand[p]) w_cand_pos = 3'(p);
    end
  end

  assign w_any_cand = |w_cand;
  assign w_good     = w_cand[r_kpos];

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_kpos_nxt   = r_kpos;
    w_word_inc   = 1'b0;
    w_bad_locked = 1'b0;
    if (!r_valid) begin
      w_state_nxt = ST_HUNT;
      w_run_nxt   = '0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_any_cand) begin
            w_kpos_nxt  = w_cand_pos;
            w_run_nxt   = 8'd1;
            w_state_nxt = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (w_good) begin
            if (r_run + 8'd1 == LP_LOCK) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = r_run + 8'd1;
            end
          end else begin
            w_state_nxt = ST_HUNT;
            w_run_nxt   = '0;
          end
        end
        ST_LOCKED: begin
          w_word_inc = 1'b1;
          if (w_good) begin
            w_run_nxt = '0;
          end else begin
            w_bad_locked = 1'b1;
            if (r_run + 8'd1 == LP_UNLOCK) begin
              w_state_nxt = ST_HUNT;
              w_run_nxt   = '0;
            end else begin
              w_run_nxt = r_run + 8'd1;
            end
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_HUNT;
      r_run   <= '0;
      r_kpos  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_kpos  <= w_kpos_nxt;
      r_err   <= w_bad_locked;
    end
  end

  // A clear takes priority over any increment in the same cycle.
  always_ff @(posedge rx_clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (r_clr) begin
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_word_inc) r_word_cnt <= r_word_cnt + 48'd1;
      if (w_bad_locked && (r_err_cnt != 32'hFFFF_FFFF)) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign locked_o   = (r_state == ST_LOCKED);
  assign k_pos_o    = r_kpos;
  assign err_o      = r_err;
  assign err_cnt_o  = r_err_cnt;
  assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_serdes_lb_checker.sv
// Bench for serdes_lb_checker: directed loopback scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_serdes_lb_checker;

  localparam logic [7:0] COMMA      = 8'hBC;
  localparam logic [7:0] FILL       = 8'h4A;
  localparam int         LOCK_CNT   = 8;
  localparam int         UNLOCK_CNT = 4;

  logic        rx_clk;
  logic        rstn_i;
  logic        rx_valid_i;
  logic [63:0] rx_data_i;
  logic [7:0]  rx_char_is_k_i;
  logic [7:0]  rx_not_in_table_i;
  logic [7:0]  rx_disp_err_i;
  logic        cnt_clr_i;
  logic        locked_o;
  logic [2:0]  k_pos_o;
  logic        err_o;
  logic [31:0] err_cnt_o;
  logic [47:0] word_cnt_o;

  serdes_lb_checker #(
    .COMMA(COMMA), .FILL(FILL), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
  ) dut (
    .rx_clk(rx_clk), .rstn_i(rstn_i), .rx_valid_i(rx_valid_i),
    .rx_data_i(rx_data_i), .rx_char_is_k_i(rx_char_is_k_i),
    .rx_not_in_table_i(rx_not_in_table_i), .rx_disp_err_i(rx_disp_err_i),
    .cnt_clr_i(cnt_clr_i), .locked_o(locked_o), .k_pos_o(k_pos_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o), .word_cnt_o(word_cnt_o)
  );

  // Clock and reset
  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: tracks the link in terms of streaks of matching words.
  bit          m_locked;
  bit          m_have_pos;
  int          m_good_streak;
  int          m_bad_streak;
  int          m_pos;
  logic [47:0] m_words;
  logic [31:0] m_errs;
  bit          m_err;

  logic        p_valid;
  logic [63:0] p_data;
  logic [7:0]  p_k, p_nit, p_disp;
  logic        p_clr;

  function automatic int cand_pos(input logic [63:0] d, input logic [7:0] k,
                                  input logic [7:0] nit, input logic [7:0] disp);
    int p;
    logic [7:0] want;
    if (nit != 0 || disp != 0) return -1;
    if ($countones(k) != 1) return -1;
    p = 0;
    for (int i = 0; i < 8; i++) if (k[i]) p = i;
    for (int i = 0; i < 8; i++) begin
      want = (i == p) ? COMMA : FILL;
      if (d[8*i +: 8] != want) return -1;
    end
    return p;
  endfunction

  function automatic logic [63:0] mk_word(input int p);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = (i == p) ? COMMA : FILL;
    return d;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have_pos = 0; m_good_streak = 0; m_bad_streak = 0;
    m_pos = 0; m_words = '0; m_errs = '0; m_err = 0;
    p_valid = 0; p_data = '0; p_k = '0; p_nit = '0; p_disp = '0; p_clr = 0;
  endtask

  task automatic model_step();
    int cp;
    cp = cand_pos(p_data, p_k, p_nit, p_disp);
    m_err = 0;
    if (!p_valid) begin
      m_locked = 0; m_have_pos = 0; m_good_streak = 0; m_bad_streak = 0;
    end else if (m_locked) begin
      m_words = m_words + 48'd1;
      if (cp == m_pos) begin
        m_bad_streak = 0;
      end else begin
        m_err = 1;
        m_bad_streak++;
        if (m_errs != 32'hFFFF_FFFF) m_errs = m_errs + 32'd1;
        if (m_bad_streak == UNLOCK_CNT) begin
          m_locked = 0; m_bad_streak = 0;
        end
      end
    end else if (m_have_pos) begin
      if (cp == m_pos) begin
        m_good_streak++;
        if (m_good_streak == LOCK_CNT) begin
          m_locked = 1; m_have_pos = 0; m_good_streak = 0; m_bad_streak = 0;
        end
      end else begin
        m_have_pos = 0; m_good_streak = 0;
      end
    end else if (cp >= 0) begin
      m_pos = cp; m_have_pos = 1; m_good_streak = 1;
    end
    if (p_clr) begin
      m_words = '0; m_errs = '0;
    end
  endtask

  // Driver: one word per cycle; outputs compared 1 time unit after the edge.
  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic [7:0] nit, input logic [7:0] disp, input logic clr);
    @(negedge rx_clk);
    rx_valid_i = v; rx_data_i = d; rx_char_is_k_i = k;
    rx_not_in_table_i = nit; rx_disp_err_i = disp; cnt_clr_i = clr;
    @(posedge rx_clk);
    model_step();
    p_valid = v; p_data = d; p_k = k; p_nit = nit; p_disp = disp; p_clr = clr;
    #1;
    check_val("locked", locked_o, m_locked);
    check_val("k_pos", k_pos_o, m_pos[2:0]);
    check_val("err", err_o, m_err);
    check_val("err_cnt", err_cnt_o, m_errs);
    check_val("word_cnt", word_cnt_o, m_words);
  endtask

  task automatic send_good(input int p, input logic clr);
    drive(1'b1, mk_word(p), 8'(1 << p), 8'h00, 8'h00, clr);
  endtask

  task automatic send_bad0(input int p, input logic clr);
    logic [63:0] d;
    d = mk_word(p);
    d[7:0] = 8'h4B;
    drive(1'b1, d, 8'(1 << p), 8'h00, 8'h00, clr);
  endtask

  task automatic send_idle();
    drive(1'b0, mk_word(0), 8'h01, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    rx_valid_i = 0; rx_data_i = '0; rx_char_is_k_i = '0;
    rx_not_in_table_i = '0; rx_disp_err_i = '0; cnt_clr_i = 0;
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_val("rst_locked", locked_o, 1'b0);
    check_val("rst_k_pos", k_pos_o, 3'd0);
    check_val("rst_err", err_o, 1'b0);
    check_val("rst_err_cnt", err_cnt_o, 32'd0);
    check_val("rst_word_cnt", word_cnt_o, 48'd0);
    repeat (3) @(posedge rx_clk);
    #1 rstn_i = 1'b1;
  endtask

  task automatic lock_run(input int p, input string tag);
    int n_lock;
    n_lock = -1;
    for (int i = 1; i <= 20; i++) begin
      send_good(p, 1'b0);
      if (locked_o && n_lock < 0) n_lock = i;
    end
    check_val(tag, n_lock, LOCK_CNT + 1);
  endtask

  initial begin
    int pulses;
    logic [47:0] saved_words;
    int pos;
    int r;
    logic [63:0] d;
    logic [7:0] k;

    apply_reset();

    // Lock onto comma at byte 3.
    lock_run(3, "lock_edges_pos3");
    check_val("kpos3", k_pos_o, 3'd3);
    check_val("no_errs_lock", err_cnt_o, 32'd0);
    check_val("word_cnt_lock", word_cnt_o, 48'd11);

    // Single corrupted byte while locked.
    pulses = 0;
    send_bad0(3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_good(3, 1'b0);
      pulses += int'(err_o);
    end
    check_val("single_err_pulses", pulses, 1);
    check_val("single_err_cnt", err_cnt_o, 32'd1);
    check_val("single_err_locked", locked_o, 1'b1);

    // Four bad words drop lock, then relock at byte 6.
    send_good(3, 1'b1);
    for (int i = 0; i < 4; i++) send_bad0(3, 1'b0);
    check_val("lock_hold_3bad", locked_o, 1'b1);
    send_good(6, 1'b0);
    check_val("unlock_err_cnt", err_cnt_o, 32'd4);
    check_val("unlock_locked", locked_o, 1'b0);
    for (int i = 0; i < 11; i++) send_good(6, 1'b0);
    check_val("relock6", locked_o, 1'b1);
    check_val("kpos6", k_pos_o, 3'd6);

    // Disparity error in SYNC restarts the hunt without counting an error.
    send_idle();
    for (int i = 0; i < 3; i++) send_good(6, 1'b0);
    drive(1'b1, mk_word(6), 8'h40, 8'h00, 8'h01, 1'b0);
    lock_run(6, "lock_after_disp");
    check_val("disp_no_err", err_cnt_o, 32'd4);

    // Clear together with a bad word.
    send_bad0(6, 1'b1);
    send_good(6, 1'b0);
    check_val("clr_err_pulse", err_o, 1'b1);
    check_val("clr_err_cnt", err_cnt_o, 32'd0);
    check_val("clr_word_cnt", word_cnt_o, 48'd0);
    send_good(6, 1'b0);
    check_val("clr_err_pulse_end", err_o, 1'b0);
    check_val("clr_word_resume", word_cnt_o, 48'd1);

    // Valid drop while locked.
    send_idle();
    saved_words = m_words;
    send_idle();
    check_val("vdrop_locked", locked_o, 1'b0);
    check_val("vdrop_hold_words", word_cnt_o, saved_words);
    lock_run(6, "lock_after_vdrop");

    // Asynchronous reset in the middle of traffic.
    @(negedge rx_clk);
    #2;
    apply_reset();
    check_val("reset_unlocked", locked_o, 1'b0);

    // Random traffic.
    pos = $urandom_range(0, 7);
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 199) == 0) pos = $urandom_range(0, 7);
      d = mk_word(pos);
      k = 8'(1 << pos);
      r = $urandom_range(0, 99);
      if (r < 82) begin
        drive(1'b1, d, k, 8'h00, 8'h00, $urandom_range(0, 99) == 0);
      end else if (r < 86) begin
        d[8*$urandom_range(0, 7) +: 8] = 8'($urandom_range(0, 255));
        drive(1'b1, d, k, 8'h00, 8'h00, 1'b0);
      end else if (r < 89) begin
        drive(1'b1, d, k, 8'h00, 8'(1 << $urandom_range(0, 7)), 1'b0);
      end else if (r < 91) begin
        drive(1'b1, d, k, 8'(1 << $urandom_range(0, 7)), 8'h00, 1'b0);
      end else if (r < 93) begin
        drive(1'b1, d, 8'($urandom_range(0, 255)), 8'h00, 8'h00, 1'b0);
      end else if (r < 95) begin
        drive(1'b0, d, k, 8'h00, 8'h00, $urandom_range(0, 3) == 0);
      end else begin
        r = $urandom_range(0, 7);
        drive(1'b1, mk_word(r), 8'(1 << r), 8'h00, 8'h00, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
